// File: rtl/qdr2p_port_arbiter.sv
// Multi-port round-robin front end for the QDR-II+ controller: one write and one read
// per cycle, in-order read tag tracking with credit limit and orphan detection.
module qdr2p_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_BITS       = 18,
    parameter int DATA_WIDTH      = 144,
    parameter int TAG_BITS        = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                   clk_ctl,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   port_wr_valid,
    output logic [NUM_PORTS-1:0]                   port_wr_ready,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]         port_wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]        port_wr_data,
    input  logic [NUM_PORTS-1:0]                   port_rd_valid,
    output logic [NUM_PORTS-1:0]                   port_rd_ready,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]         port_rd_addr,
    input  logic [NUM_PORTS*TAG_BITS-1:0]          port_rd_tag,
    output logic [NUM_PORTS-1:0]                   port_rsp_valid,
    output logic [TAG_BITS-1:0]                    port_rsp_tag,
    output logic [DATA_WIDTH-1:0]                  port_rsp_data,
    output logic                                   mem_wr_en,
    output logic [ADDR_BITS-1:0]                   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                  mem_wr_data,
    output logic                                   mem_rd_en,
    output logic [ADDR_BITS-1:0]                   mem_rd_addr,
    input  logic                                   mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]                  mem_rd_data,
    output logic [$clog2(MAX_OUTSTANDING):0]       rd_outstanding,
    output logic                                   rsp_orphan
);

    localparam int PIDX_W = $clog2(NUM_PORTS);
    localparam int QPTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = QPTR_W + 1;

    // Returns {found, index} of the first requester at or above ptr, wrapping.
    function automatic logic [PIDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [PIDX_W-1:0]    ptr);
        logic [PIDX_W:0] res;
        int              j;
        res = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end else begin
                j = j;
            end
            if (!res[PIDX_W] && req[PIDX_W'(j)]) begin
                res = {1'b1, PIDX_W'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [PIDX_W-1:0] rr_next(input logic [PIDX_W-1:0] idx);
        logic [PIDX_W-1:0] nxt;
        if (idx == PIDX_W'(NUM_PORTS - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + PIDX_W'(1);
        end
        return nxt;
    endfunction

    logic [PIDX_W-1:0]     wr_rr_q, rd_rr_q;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [QPTR_W-1:0]     q_wptr_q, q_rptr_q;
    logic [PIDX_W-1:0]     q_port_mem [MAX_OUTSTANDING];
    logic [TAG_BITS-1:0]   q_tag_mem  [MAX_OUTSTANDING];

    logic                  mem_wr_en_q, mem_rd_en_q;
    logic [ADDR_BITS-1:0]  mem_wr_addr_q, mem_rd_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic [NUM_PORTS-1:0]  rsp_valid_q;
    logic [TAG_BITS-1:0]   rsp_tag_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  orphan_q;

    logic [PIDX_W:0]       wr_pick_s, rd_pick_s;
    logic                  wr_found_s, rd_found_s;
    logic [PIDX_W-1:0]     wr_idx_s, rd_idx_s;
    logic                  rd_credit_s, push_s, pop_s, orphan_s;

    // Arbitration, credit gating and queue push/pop decisions.
    always_comb begin
        rd_credit_s = (rd_cnt_q < CNT_W'(MAX_OUTSTANDING));
        wr_pick_s   = rr_pick(port_wr_valid, wr_rr_q);
        rd_pick_s   = rr_pick(port_rd_valid & {NUM_PORTS{rd_credit_s}}, rd_rr_q);
        wr_found_s  = wr_pick_s[PIDX_W] & ~rst;
        rd_found_s  = rd_pick_s[PIDX_W] & ~rst;
        wr_idx_s    = wr_pick_s[PIDX_W-1:0];
        rd_idx_s    = rd_pick_s[PIDX_W-1:0];
        push_s      = rd_found_s;
        // Emptiness is judged on the registered count, before any same-cycle push.
        pop_s       = mem_rd_valid && (rd_cnt_q != CNT_W'(0));
        orphan_s    = mem_rd_valid && (rd_cnt_q == CNT_W'(0));
        if (wr_found_s) begin
            port_wr_ready = NUM_PORTS'(1'b1) << wr_idx_s;
        end else begin
            port_wr_ready = '0;
        end
        if (rd_found_s) begin
            port_rd_ready = NUM_PORTS'(1'b1) << rd_idx_s;
        end else begin
            port_rd_ready = '0;
        end
    end

    // Outstanding-read count next state.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
            2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    // Tracking queue storage; contents are don't-care until pushed.
    always_ff @(posedge clk_ctl) begin
        if (push_s) begin
            q_port_mem[q_wptr_q] <= rd_idx_s;
            q_tag_mem[q_wptr_q]  <= port_rd_tag[rd_idx_s*TAG_BITS +: TAG_BITS];
        end
    end

    // Pointers, counters and all registered outputs.
    always_ff @(posedge clk_ctl or posedge rst) begin
        if (rst) begin
            wr_rr_q       <= '0;
            rd_rr_q       <= '0;
            rd_cnt_q      <= '0;
            q_wptr_q      <= '0;
            q_rptr_q      <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            rsp_valid_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_data_q    <= '0;
            orphan_q      <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            mem_wr_en_q <= wr_found_s;
            mem_rd_en_q <= rd_found_s;
            if (wr_found_s) begin
                wr_rr_q       <= rr_next(wr_idx_s);
                mem_wr_addr_q <= port_wr_addr[wr_idx_s*ADDR_BITS +: ADDR_BITS];
                mem_wr_data_q <= port_wr_data[wr_idx_s*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                mem_wr_addr_q <= '0;
                mem_wr_data_q <= '0;
            end
            if (rd_found_s) begin
                rd_rr_q       <= rr_next(rd_idx_s);
                q_wptr_q      <= q_wptr_q + QPTR_W'(1);
                mem_rd_addr_q <= port_rd_addr[rd_idx_s*ADDR_BITS +: ADDR_BITS];
            end else begin
                mem_rd_addr_q <= '0;
            end
            if (pop_s) begin
                q_rptr_q    <= q_rptr_q + QPTR_W'(1);
                rsp_valid_q <= NUM_PORTS'(1'b1) << q_port_mem[q_rptr_q];
                rsp_tag_q   <= q_tag_mem[q_rptr_q];
                rsp_data_q  <= mem_rd_data;
            end else begin
                rsp_valid_q <= '0;
                rsp_tag_q   <= '0;
                rsp_data_q  <= '0;
            end
            if (orphan_s) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign mem_wr_en      = mem_wr_en_q;
    assign mem_wr_addr    = mem_wr_addr_q;
    assign mem_wr_data    = mem_wr_data_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_rd_addr    = mem_rd_addr_q;
    assign port_rsp_valid = rsp_valid_q;
    assign port_rsp_tag   = rsp_tag_q;
    assign port_rsp_data  = rsp_data_q;
    assign rd_outstanding = rd_cnt_q;
    assign rsp_orphan     = orphan_q;

endmodule

// File: tb/tb_qdr2p_port_arbiter.sv
// Directed bench for qdr2p_port_arbiter: round-robin, concurrency, tag routing,
// credit limit, orphan detection and mid-flight reset.
module tb_qdr2p_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 18;
    localparam int DW = 144;
    localparam int TW = 4;

    logic               clk_ctl;
    logic               rst;
    logic [NP-1:0]      port_wr_valid, port_wr_ready;
    logic [NP*AW-1:0]   port_wr_addr;
    logic [NP*DW-1:0]   port_wr_data;
    logic [NP-1:0]      port_rd_valid, port_rd_ready;
    logic [NP*AW-1:0]   port_rd_addr;
    logic [NP*TW-1:0]   port_rd_tag;
    logic [NP-1:0]      port_rsp_valid;
    logic [TW-1:0]      port_rsp_tag;
    logic [DW-1:0]      port_rsp_data;
    logic               mem_wr_en, mem_rd_en, mem_rd_valid;
    logic [AW-1:0]      mem_wr_addr, mem_rd_addr;
    logic [DW-1:0]      mem_wr_data, mem_rd_data;
    logic [4:0]         rd_outstanding;
    logic               rsp_orphan;

    int n_cmp = 0;
    int n_err = 0;

    qdr2p_port_arbiter dut (
        .clk_ctl(clk_ctl), .rst(rst),
        .port_wr_valid(port_wr_valid), .port_wr_ready(port_wr_ready),
        .port_wr_addr(port_wr_addr), .port_wr_data(port_wr_data),
        .port_rd_valid(port_rd_valid), .port_rd_ready(port_rd_ready),
        .port_rd_addr(port_rd_addr), .port_rd_tag(port_rd_tag),
        .port_rsp_valid(port_rsp_valid), .port_rsp_tag(port_rsp_tag),
        .port_rsp_data(port_rsp_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .rd_outstanding(rd_outstanding), .rsp_orphan(rsp_orphan)
    );

    initial clk_ctl = 1'b0;
    always #5 clk_ctl = ~clk_ctl;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_ctl);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        int p;
        rst = 1'b1;
        port_wr_valid = '0; port_wr_addr = '0; port_wr_data = '0;
        port_rd_valid = '0; port_rd_addr = '0; port_rd_tag = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;

        // Reset state
        tick;
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_cnt", rd_outstanding, 5'd0);
        check("rst_orphan", rsp_orphan, 1'b0);
        check("rst_rsp_valid", port_rsp_valid, 4'b0000);
        tick;
        rst = 1'b0;

        // Write round-robin
        for (int i = 0; i < NP; i++) begin
            b = 8'h10 + 8'(i);
            port_wr_addr[i*AW +: AW] = 18'h100 + 18'(i);
            port_wr_data[i*DW +: DW] = {18{b}};
        end
        port_wr_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            p = k % 4;
            b = 8'h10 + 8'(p);
            #1;
            check("wr_rr_ready", port_wr_ready, 160'd1 << p);
            tick;
            check("wr_rr_en", mem_wr_en, 1'b1);
            check("wr_rr_addr", mem_wr_addr, 18'h100 + 18'(p));
            check("wr_rr_data", mem_wr_data, {18{b}});
            if (k == 4) port_wr_valid = 4'h0;
        end
        tick;
        check("wr_idle_en", mem_wr_en, 1'b0);
        check("wr_idle_addr", mem_wr_addr, 18'h0);
        check("wr_idle_data", mem_wr_data, 144'h0);

        // Concurrent read and write (wr pointer at 1, rd pointer at 0)
        port_wr_valid = 4'b0100; port_wr_addr[2*AW +: AW] = 18'h00A;
        port_rd_valid = 4'b0010; port_rd_addr[1*AW +: AW] = 18'h00B;
        port_rd_tag[1*TW +: TW] = 4'h5;
        #1;
        check("cc_wr_ready", port_wr_ready, 4'b0100);
        check("cc_rd_ready", port_rd_ready, 4'b0010);
        tick;
        port_wr_valid = 4'h0; port_rd_valid = 4'h0;
        check("cc_wr_en", mem_wr_en, 1'b1);
        check("cc_wr_addr", mem_wr_addr, 18'h00A);
        check("cc_rd_en", mem_rd_en, 1'b1);
        check("cc_rd_addr", mem_rd_addr, 18'h00B);
        check("cc_cnt", rd_outstanding, 5'd1);
        mem_rd_valid = 1'b1; mem_rd_data = {18{8'h5A}};
        tick;
        mem_rd_valid = 1'b0;
        check("cc_rsp_valid", port_rsp_valid, 4'b0010);
        check("cc_rsp_tag", port_rsp_tag, 4'h5);
        check("cc_rsp_data", port_rsp_data, {18{8'h5A}});
        check("cc_cnt0", rd_outstanding, 5'd0);
        check("cc_rd_idle_addr", mem_rd_addr, 18'h0);
        tick;
        check("rsp_idle_valid", port_rsp_valid, 4'b0000);
        check("rsp_idle_tag", port_rsp_tag, 4'h0);
        check("rsp_idle_data", port_rsp_data, 144'h0);

        // Tag routing (rd pointer at 2)
        port_rd_valid = 4'b0001; port_rd_addr[0 +: AW] = 18'h020; port_rd_tag[0 +: TW] = 4'h3;
        #1;
        check("tr_ready0", port_rd_ready, 4'b0001);
        tick;
        check("tr_addr0", mem_rd_addr, 18'h020);
        port_rd_valid = 4'b1000; port_rd_addr[3*AW +: AW] = 18'h023; port_rd_tag[3*TW +: TW] = 4'h9;
        #1;
        check("tr_ready3", port_rd_ready, 4'b1000);
        tick;
        port_rd_valid = 4'h0;
        check("tr_cnt2", rd_outstanding, 5'd2);
        mem_rd_valid = 1'b1; mem_rd_data = {18{8'hAA}};
        tick;
        check("tr_rsp0_valid", port_rsp_valid, 4'b0001);
        check("tr_rsp0_tag", port_rsp_tag, 4'h3);
        check("tr_rsp0_data", port_rsp_data, {18{8'hAA}});
        mem_rd_data = {18{8'hBB}};
        tick;
        mem_rd_valid = 1'b0;
        check("tr_rsp1_valid", port_rsp_valid, 4'b1000);
        check("tr_rsp1_tag", port_rsp_tag, 4'h9);
        check("tr_rsp1_data", port_rsp_data, {18{8'hBB}});
        check("tr_cnt0", rd_outstanding, 5'd0);

        // Credit limit (rd pointer at 0)
        for (int i = 0; i < NP; i++) begin
            port_rd_addr[i*AW +: AW] = 18'h200 + 18'(i);
            port_rd_tag[i*TW +: TW]  = 4'hC + 4'(i);
        end
        port_rd_valid = 4'hF;
        for (int k = 0; k < 16; k++) tick;
        check("cr_cnt16", rd_outstanding, 5'd16);
        check("cr_ready0", port_rd_ready, 4'b0000);
        check("cr_last_en", mem_rd_en, 1'b1);
        tick;
        check("cr_hold_cnt", rd_outstanding, 5'd16);
        check("cr_hold_en", mem_rd_en, 1'b0);
        mem_rd_valid = 1'b1; mem_rd_data = {18{8'hC3}};
        #1;
        check("cr_same_cycle_blocked", port_rd_ready, 4'b0000);
        tick;
        mem_rd_valid = 1'b0;
        check("cr_pop_valid", port_rsp_valid, 4'b0001);
        check("cr_pop_tag", port_rsp_tag, 4'hC);
        check("cr_cnt15", rd_outstanding, 5'd15);
        check("cr_regrant", port_rd_ready, 4'b0001);
        tick;
        port_rd_valid = 4'h0;
        check("cr_cnt_back16", rd_outstanding, 5'd16);
        check("cr_regrant_en", mem_rd_en, 1'b1);
        check("cr_regrant_addr", mem_rd_addr, 18'h200);
        mem_rd_valid = 1'b1;
        for (int k = 0; k < 16; k++) tick;
        mem_rd_valid = 1'b0;
        check("cr_drain_cnt", rd_outstanding, 5'd0);
        check("cr_drain_last_valid", port_rsp_valid, 4'b0001);
        check("cr_drain_last_tag", port_rsp_tag, 4'hC);
        check("cr_no_orphan", rsp_orphan, 1'b0);

        // Orphan with simultaneous push (rd pointer at 1)
        port_rd_valid = 4'b0100; mem_rd_valid = 1'b1; mem_rd_data = {18{8'h77}};
        #1;
        check("or_ready", port_rd_ready, 4'b0100);
        tick;
        port_rd_valid = 4'h0; mem_rd_valid = 1'b0;
        check("or_flag", rsp_orphan, 1'b1);
        check("or_no_rsp", port_rsp_valid, 4'b0000);
        check("or_no_data", port_rsp_data, 144'h0);
        check("or_cnt1", rd_outstanding, 5'd1);
        check("or_addr", mem_rd_addr, 18'h202);
        tick;
        check("or_sticky", rsp_orphan, 1'b1);

        // Reset mid-flight (rd pointer at 3, wr pointer at 3)
        port_rd_valid = 4'hF;
        for (int k = 0; k < 4; k++) tick;
        check("rm_cnt5", rd_outstanding, 5'd5);
        check("rm_en_before", mem_rd_en, 1'b1);
        rst = 1'b1;
        #1;
        check("rm_async_en", mem_rd_en, 1'b0);
        check("rm_async_addr", mem_rd_addr, 18'h0);
        check("rm_async_cnt", rd_outstanding, 5'd0);
        check("rm_async_orphan", rsp_orphan, 1'b0);
        check("rm_async_ready", port_rd_ready, 4'b0000);
        tick;
        rst = 1'b0;
        port_wr_valid = 4'hF; mem_rd_valid = 1'b1;
        #1;
        check("rm_rd_restart", port_rd_ready, 4'b0001);
        check("rm_wr_restart", port_wr_ready, 4'b0001);
        tick;
        port_rd_valid = 4'h0; port_wr_valid = 4'h0; mem_rd_valid = 1'b0;
        check("rm_orphan", rsp_orphan, 1'b1);
        check("rm_no_rsp", port_rsp_valid, 4'b0000);
        check("rm_cnt1", rd_outstanding, 5'd1);
        check("rm_rd_addr", mem_rd_addr, 18'h200);
        check("rm_wr_addr", mem_wr_addr, 18'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qdr2p_port_arbiter.md
# qdr2p_port_arbiter

Multi-port request front end for the QDR-II+ controller, living entirely in the controller clock domain. It round-robin arbitrates NUM_PORTS independent read and write request streams onto the single-read plus single-write per cycle controller interface. It tracks every issued read in an in-order tag queue and routes each returning burst back to the originating port with that port's tag. Outstanding reads are credit-limited, and responses arriving with no matching queued read are flagged.

## Interface
Parameters:
- NUM_PORTS, 4, number of client ports (2..8)
- ADDR_BITS, 18, word address width
- DATA_WIDTH, 144, burst width (4 × RAM_WIDTH)
- TAG_BITS, 4, client read tag width
- MAX_OUTSTANDING, 16, read tracking depth, power of two

Ports (per-port buses are packed with port i at [i*W +: W]):
- clk_ctl  in  1  controller clock; sole clock
- rst  in  1  asynchronous, active-high reset
- port_wr_valid  in  NUM_PORTS  write request per port
- port_wr_ready  out  NUM_PORTS  write grant, one-hot or zero
- port_wr_addr  in  NUM_PORTS*ADDR_BITS  write addresses
- port_wr_data  in  NUM_PORTS*DATA_WIDTH  write bursts
- port_rd_valid  in  NUM_PORTS  read request per port
- port_rd_ready  out  NUM_PORTS  read grant, one-hot or zero
- port_rd_addr  in  NUM_PORTS*ADDR_BITS  read addresses
- port_rd_tag  in  NUM_PORTS*TAG_BITS  client read tags
- port_rsp_valid  out  NUM_PORTS  response strobe, one-hot or zero
- port_rsp_tag  out  TAG_BITS  tag of the current response (shared)
- port_rsp_data  out  DATA_WIDTH  response burst (shared)
- mem_wr_en / mem_wr_addr / mem_wr_data  out  1 / ADDR_BITS / DATA_WIDTH  to controller write port
- mem_rd_en / mem_rd_addr  out  1 / ADDR_BITS  to controller read port
- mem_rd_valid / mem_rd_data  in  1 / DATA_WIDTH  from controller, in-order completions
- rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads issued and not yet returned
- rsp_orphan  out  1  sticky: a response arrived with the tracking queue empty

## Operation
- Write and read arbitration are independent. Each cycle, up to one write and one read may be accepted.
- **Round-robin:** each arbiter keeps a pointer wr_rr / rd_rr. The grant goes to the first valid port scanning from the pointer upward, wrapping modulo NUM_PORTS.
  - On a grant to port i, the pointer becomes (i+1) mod NUM_PORTS.
  - With no grant, the pointer holds.
- **Ready/transfer:** ready is combinational from valid, the pointer and credit state. A transfer occurs when valid && ready. Clients must hold valid and payload stable until ready.
- **Read credit:** a read may be granted only if rd_outstanding < MAX_OUTSTANDING. A response in the same cycle does not free a credit until the next cycle.
  - While credit is exhausted, port_rd_ready = 0 and rd_rr holds.
- **Tracking queue:** each granted read pushes {port index, tag} into a MAX_OUTSTANDING-deep FIFO.
  - Each mem_rd_valid pops the head and steers mem_rd_data to that port with that tag.
- **Counter:** rd_outstanding increments on push and decrements on pop. Simultaneous push and pop leaves it unchanged.
- **Orphan:** mem_rd_valid with the queue empty is judged before any same-cycle push.
  - The response is dropped, with no port_rsp_valid.
  - rsp_orphan is set and stays set until rst.
- Writes carry no tracking state. No read/write address hazard checking is performed; ordering is as the RAM provides.
- **Reset (any time):** all outputs go to 0, pointers to 0, queue empty, count 0. In-flight reads are forgotten, so their later responses are orphans.

## Timing
- Grant to controller: 1 cycle. mem_wr_en, mem_wr_addr and mem_wr_data are registered outputs asserted the cycle after the write transfer; mem_rd_* likewise.
- mem_wr_en / mem_rd_en are high for exactly one cycle per accepted request. Back-to-back grants give back-to-back enables.
- Idle outputs: mem_*_addr and mem_wr_data drive 0 when the enable is low.
- Response: port_rsp_valid, tag and data are registered outputs asserted the cycle after mem_rd_valid. There is no response backpressure; clients must sink every cycle.
- port_rsp_data and port_rsp_tag are 0 when no response is valid.
- rd_outstanding is registered and reflects pushes and pops of the previous cycle.
- The queue pointers wrap modulo MAX_OUTSTANDING. Full means rd_outstanding == MAX_OUTSTANDING.

## Test plan
- **Write round-robin:** all four ports hold wr_valid with addr = 0x100+i.
  - Grants go 0,1,2,3,0.
  - mem_wr_addr shows 0x100,0x101,0x102,0x103,0x100 on consecutive cycles, each one cycle after its ready.
- **Concurrent read/write:** port 2 writes 0x00A and port 1 reads 0x00B in the same cycle.
  - Next cycle, mem_wr_en = mem_rd_en = 1 with mem_wr_addr = 0x00A and mem_rd_addr = 0x00B.
- **Tag routing:** port 0 reads tag 0x3, then port 3 reads tag 0x9. Return two responses 0xAA.., then 0xBB...
  - Expect port_rsp_valid = 0001 with tag 0x3 and data 0xAA.., then 1000 with tag 0x9 and data 0xBB.., each one cycle after mem_rd_valid.
- **Credit limit:** issue 16 reads with no responses.
  - rd_outstanding = 16 and all rd_ready stay 0.
  - One response leaves a grant blocked in that same cycle; a grant appears the next cycle and the count returns to 16.
- **Orphan:** with the queue empty, pulse mem_rd_valid.
  - rsp_orphan = 1 and no port_rsp_valid.
  - A simultaneous push is retained, so rd_outstanding = 1.
- **Reset mid-flight:** with 5 reads outstanding, assert rst for 1 cycle.
  - All outputs go to 0 asynchronously.
  - After release, a response sets rsp_orphan and arbitration restarts at port 0.
